// File: rtl/core_ctrl_pkg.sv
// Shared constants, state encoding and fetch bundle
// for the xRV32I PC/fetch controller.
package core_ctrl_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [31:0] CPU_RST_ADDRESS = 32'h0000_0000;
  localparam logic HOLD_ENABLE = 1'b1;
  localparam logic JUMP_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    CTRL_ST_RESET = 2'd0,
    CTRL_ST_RUN   = 2'd1,
    CTRL_ST_KILL  = 2'd2,
    CTRL_ST_HOLD  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } fetch_t;

endpackage

// File: rtl/core_if_skid.sv
// One-entry skid buffer catching a fetch response
// that lands while the pipeline is held.
module core_if_skid
  import core_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  fetch_t din,
  output logic   valid,
  output fetch_t dout
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end
  end

endmodule

// File: rtl/core_ctrl.sv
// PC owner and single-outstanding fetch controller
// feeding the IF/ID register.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_ADDR = CPU_RST_ADDRESS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_in,
  input  logic [31:0] jump_addr_in,
  input  logic        hold_flag_in,
  input  logic        hold_ext_in,
  output logic        ifetch_req_out,
  output logic [31:0] ifetch_addr_out,
  input  logic        ifetch_ack_in,
  input  logic [31:0] ifetch_data_in,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out,
  output logic        inst_valid_out,
  output logic        hold_out,
  output logic        flush_out,
  output logic        misalign_out
);

  ctrl_state_e state, state_n;

  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic        pending;
  logic        hold;
  logic        jump;
  logic        issue;
  logic        ack;
  logic        keep;
  logic        skid_valid;
  logic        skid_load;
  logic        skid_clear;
  fetch_t      skid_q;
  fetch_t      resp;

  assign hold = (hold_flag_in == HOLD_ENABLE)
              | (hold_ext_in == HOLD_ENABLE);
  assign jump = (jump_flag_in == JUMP_ENABLE)
              & (state != CTRL_ST_RESET);

  // jump outranks fetch: no new request in a redirect cycle
  assign issue = (state == CTRL_ST_RUN) & ~pending
               & ~skid_valid & ~hold & ~jump;

  assign ifetch_req_out  = pending | issue;
  assign ifetch_addr_out = pending ? fetch_addr : pc;
  assign ack  = ifetch_ack_in & ifetch_req_out;
  assign keep = ack & ~jump & (state != CTRL_ST_KILL);
  assign resp = '{inst: ifetch_data_in,
                  addr: ifetch_addr_out};

  assign hold_out     = hold;
  assign flush_out    = jump;
  assign misalign_out = jump & (|jump_addr_in[1:0]);

  assign skid_load  = keep & hold;
  assign skid_clear = jump | (~hold & skid_valid);

  core_if_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (resp),
    .valid (skid_valid),
    .dout  (skid_q)
  );

  always_comb begin
    state_n = state;
    if (jump) begin
      state_n = (pending & ~ack) ? CTRL_ST_KILL
                                 : CTRL_ST_RUN;
    end else begin
      case (state)
        CTRL_ST_RESET: state_n = CTRL_ST_RUN;
        CTRL_ST_RUN:
          if (hold) state_n = CTRL_ST_HOLD;
        CTRL_ST_KILL:
          if (ack) state_n = CTRL_ST_RUN;
        CTRL_ST_HOLD:
          if (!hold) state_n = CTRL_ST_RUN;
        default: state_n = CTRL_ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CTRL_ST_RESET;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RST_ADDR;
      fetch_addr <= RST_ADDR;
      pending    <= 1'b0;
    end else begin
      if (jump)
        pc <= {jump_addr_in[31:2], 2'b00};
      else if (issue)
        pc <= pc + 32'd4;
      if (issue)
        fetch_addr <= pc;
      pending <= (pending | issue) & ~ack;
    end
  end

  // skid entry drains before any fresh response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_out       <= INST_NOP;
      inst_addr_out  <= RST_ADDR;
      inst_valid_out <= 1'b0;
    end else if (jump) begin
      inst_out       <= INST_NOP;
      inst_valid_out <= 1'b0;
    end else if (hold) begin
      inst_valid_out <= inst_valid_out;
    end else if (skid_valid) begin
      inst_out       <= skid_q.inst;
      inst_addr_out  <= skid_q.addr;
      inst_valid_out <= 1'b1;
    end else if (keep) begin
      inst_out       <= resp.inst;
      inst_addr_out  <= resp.addr;
      inst_valid_out <= 1'b1;
    end else begin
      inst_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Scoreboard bench for core_ctrl: directed
// per-cycle vectors, decoupled monitor.
module tb_core_ctrl;
  import core_ctrl_pkg::*;

  localparam logic [31:0] RA = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_flag_in = 1'b0;
  logic [31:0] jump_addr_in = '0;
  logic        hold_flag_in = 1'b0;
  logic        hold_ext_in = 1'b0;
  logic        ifetch_req_out;
  logic [31:0] ifetch_addr_out;
  logic        ifetch_ack_in;
  logic [31:0] ifetch_data_in;
  logic [31:0] inst_out;
  logic [31:0] inst_addr_out;
  logic        inst_valid_out;
  logic        hold_out;
  logic        flush_out;
  logic        misalign_out;

  logic ack_en = 1'b0;
  logic ovr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_ctrl #(.RST_ADDR(RA)) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_in    (jump_flag_in),
    .jump_addr_in    (jump_addr_in),
    .hold_flag_in    (hold_flag_in),
    .hold_ext_in     (hold_ext_in),
    .ifetch_req_out  (ifetch_req_out),
    .ifetch_addr_out (ifetch_addr_out),
    .ifetch_ack_in   (ifetch_ack_in),
    .ifetch_data_in  (ifetch_data_in),
    .inst_out        (inst_out),
    .inst_addr_out   (inst_addr_out),
    .inst_valid_out  (inst_valid_out),
    .hold_out        (hold_out),
    .flush_out       (flush_out),
    .misalign_out    (misalign_out)
  );

  function automatic logic [31:0] mem(
    input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  // instruction memory model
  assign ifetch_ack_in  = ack_en & ifetch_req_out;
  assign ifetch_data_in = ovr ? 32'hDEAD_BEEF
                              : mem(ifetch_addr_out);

  typedef struct {
    logic        r, a, j;
    logic [31:0] ja;
    logic        hf, he, ov;
    logic        e_req, e_v, e_fl, e_mis;
  } vec_t;

  typedef struct {
    logic r, req, v, fl, mis, hld;
  } cyc_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } inst_t;

  vec_t        vq[$];
  cyc_t        exp_cyc[$];
  logic [31:0] exp_req[$];
  inst_t       exp_inst[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  task automatic add(
    input logic r, a, j,
    input logic [31:0] ja,
    input logic hf, he, ov,
    input logic er, ev, ef, em);
    vec_t v;
    v.r = r; v.a = a; v.j = j; v.ja = ja;
    v.hf = hf; v.he = he; v.ov = ov;
    v.e_req = er; v.e_v = ev;
    v.e_fl = ef; v.e_mis = em;
    vq.push_back(v);
  endtask

  task automatic push_i(input logic [31:0] a);
    inst_t t;
    t.a = a;
    t.d = mem(a);
    exp_inst.push_back(t);
  endtask

  logic hold_prev = 1'b0;

  always @(negedge clk) begin
    cyc_t  c;
    inst_t t;
    if (exp_cyc.size() > 0) begin
      c = exp_cyc.pop_front();
      chk("req", {31'd0, ifetch_req_out},
          {31'd0, c.req});
      chk("valid", {31'd0, inst_valid_out},
          {31'd0, c.v});
      chk("flush", {31'd0, flush_out},
          {31'd0, c.fl});
      chk("misalign", {31'd0, misalign_out},
          {31'd0, c.mis});
      chk("hold_out", {31'd0, hold_out},
          {31'd0, c.hld});
      if (c.r) begin
        chk("rst_inst", inst_out, INST_NOP);
        chk("rst_iaddr", inst_addr_out, RA);
      end
    end
    if (ifetch_req_out && ifetch_ack_in) begin
      if (exp_req.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL req_extra actual=%h required=none",
                 ifetch_addr_out);
      end else begin
        chk("req_addr", ifetch_addr_out,
            exp_req.pop_front());
      end
    end
    if (inst_valid_out && !hold_prev) begin
      if (exp_inst.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL inst_extra actual=%h required=none",
                 inst_addr_out);
      end else begin
        t = exp_inst.pop_front();
        chk("inst_addr", inst_addr_out, t.a);
        chk("inst_data", inst_out, t.d);
      end
    end
    hold_prev = hold_out;
  end

  initial begin
    // rst ack jmp ja hf he ovr | req v fl mis
    add(0,1,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,1,1,32'h100,0,0,0, 0,1,1,0);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,1,32'h10,0,0,0, 0,1,1,0);
    add(0,0,0,0,0,0,0, 1,0,0,0);
    add(0,0,1,32'h200,0,0,0, 1,0,1,0);
    add(0,0,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,1,1,32'h20,0,0,0, 0,1,1,0);
    add(0,0,0,0,0,0,0, 1,0,0,0);
    add(0,0,0,0,1,0,0, 1,0,0,0);
    add(0,1,0,0,1,0,1, 1,0,0,0);
    add(0,1,0,0,1,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,1,1,32'h102,0,0,0, 0,1,1,1);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,1,0, 1,0,0,0);
    add(0,1,0,0,0,1,0, 1,0,0,0);
    add(1,0,0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,0, 1,0,0,0);
    add(0,1,0,0,0,0,0, 1,1,0,0);
    add(0,0,0,0,0,0,0, 1,1,0,0);

    exp_req = '{32'h0, 32'h4, 32'h8,
                32'h100, 32'h10, 32'h200,
                32'h204, 32'h20, 32'h24,
                32'h28, 32'h100, 32'h104,
                32'h108, 32'h0, 32'h4};

    push_i(32'h0);
    push_i(32'h4);
    push_i(32'h8);
    push_i(32'h100);
    push_i(32'h200);
    push_i(32'h204);
    exp_inst.push_back('{a: 32'h20,
                         d: 32'hDEAD_BEEF});
    push_i(32'h24);
    push_i(32'h28);
    push_i(32'h100);
    push_i(32'h104);
    push_i(RA);
    push_i(RA + 32'h4);

    @(negedge clk);
    chk("reset_req", {31'd0, ifetch_req_out}, 0);
    chk("reset_valid", {31'd0, inst_valid_out}, 0);
    chk("reset_inst", inst_out, INST_NOP);
    chk("reset_iaddr", inst_addr_out, RA);
    chk("reset_mis", {31'd0, misalign_out}, 0);
    chk("reset_flush", {31'd0, flush_out}, 0);

    repeat (2) @(posedge clk);
    foreach (vq[i]) begin
      cyc_t c;
      @(posedge clk);
      #1;
      rst          = vq[i].r;
      ack_en       = vq[i].a;
      jump_flag_in = vq[i].j;
      jump_addr_in = vq[i].ja;
      hold_flag_in = vq[i].hf;
      hold_ext_in  = vq[i].he;
      ovr          = vq[i].ov;
      c.r   = vq[i].r;
      c.req = vq[i].e_req;
      c.v   = vq[i].e_v;
      c.fl  = vq[i].e_fl;
      c.mis = vq[i].e_mis;
      c.hld = vq[i].hf | vq[i].he;
      exp_cyc.push_back(c);
    end

    @(posedge clk);
    #1;
    ack_en       = 1'b0;
    jump_flag_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("req_left", exp_req.size(), 0);
    chk("inst_left", exp_inst.size(), 0);
    chk("cyc_left", exp_cyc.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
